vram_burst_fetch: RTL and testbench

// - Burst reader between a video fetch client (layer/sprite renderer) and one 32-bit read-only port (if1/if2/if3) of vram_if.
// - Given a start word address and word count, issues back-to-back word reads under vram_if priority arbitration.
// - Buffers returned words in a small FIFO; the renderer pops them with a valid/ready handshake.

---
 rtl/vram_burst_fetch_if.sv | 28 ++
 rtl/vram_burst_fetch.sv | 156 +++++++++++++++
 tb/tb_vram_burst_fetch.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/vram_burst_fetch_if.sv
// Signal bundle between vram_burst_fetch, its video fetch client and one
// read-only vram_if port: burst control, VRAM bus and output word stream.
interface vram_burst_fetch_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [14:0]      start_addr;
    logic [CNT_W-1:0] word_count;
    logic             busy;
    logic             done;
    logic [14:0]      bus_addr;
    logic             bus_strobe;
    logic             bus_ack;
    logic [31:0]      bus_rddata;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_ready;

    modport slave (
        input  start, start_addr, word_count, bus_ack, bus_rddata, out_ready,
        output busy, done, bus_addr, bus_strobe, out_valid, out_data
    );

    modport master (
        output start, start_addr, word_count, bus_ack, bus_rddata, out_ready,
        input  busy, done, bus_addr, bus_strobe, out_valid, out_data
    );
endinterface

// File: rtl/vram_burst_fetch.sv
// Burst reader: streams word_count consecutive VRAM words from a vram_if read
// port into a small first-word-fall-through FIFO drained by a valid/ready client.
module vram_burst_fetch #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    vram_burst_fetch_if.slave bif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_C  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [14:0]      last_addr_q, last_addr_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [AW:0]      fcount_q, fcount_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic             strobe_q, strobe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             ack_s;
    logic             push_s;
    logic             pop_s;
    logic             strobe_s;
    logic [14:0]      bus_addr_s;
    logic [CNT_W-1:0] remain_left_s;
    logic [AW:0]      fcount_fill_s;

    // Bus side: an ack only counts when it answers a strobe of the previous cycle.
    always_comb begin
        ack_s         = bif.bus_ack & strobe_q;
        push_s        = ack_s & (state_q != ST_IDLE);
        pop_s         = (fcount_q != '0) & bif.out_ready;
        bus_addr_s    = last_addr_q + 15'(ack_s);
        remain_left_s = remain_q - CNT_W'(ack_s);
        fcount_fill_s = fcount_q + (AW + 1)'(ack_s);
        strobe_s      = (state_q == ST_FETCH) && (remain_left_s != '0) &&
                        (fcount_fill_s < FULL_C);
    end

    // FIFO storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcount_d = fcount_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = bif.bus_rddata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   fcount_d = fcount_q + CNT_ONE;
            2'b01:   fcount_d = fcount_q - CNT_ONE;
            default: fcount_d = fcount_q;
        endcase
    end

    // Burst sequencing: IDLE -> FETCH until every word is acked -> DRAIN until the FIFO empties.
    always_comb begin
        state_d     = state_q;
        last_addr_d = last_addr_q;
        remain_d    = remain_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bif.start) begin
                    if (bif.word_count != '0) begin
                        state_d     = ST_FETCH;
                        last_addr_d = bif.start_addr;
                        remain_d    = bif.word_count;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                last_addr_d = bus_addr_s;
                remain_d    = remain_left_s;
                if (remain_left_s == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (fcount_d == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        strobe_d = strobe_s;
        busy_d   = (state_d != ST_IDLE);
    end

    // State register; reset discards any burst in flight and the FIFO contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_addr_q <= 15'd0;
            remain_q    <= '0;
            fcount_q    <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            state_q     <= state_d;
            last_addr_q <= last_addr_d;
            remain_q    <= remain_d;
            fcount_q    <= fcount_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            strobe_q    <= strobe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_q       <= mem_d;
        end
    end

    assign bif.bus_addr   = bus_addr_s;
    assign bif.bus_strobe = strobe_s;
    assign bif.busy       = busy_q;
    assign bif.done       = done_q;
    assign bif.out_valid  = (fcount_q != '0);
    assign bif.out_data   = (fcount_q != '0) ? mem_q[rd_ptr_q] : 32'd0;
endmodule

// File: tb/tb_vram_burst_fetch.sv
// Randomized bench for vram_burst_fetch: plays the vram_if port and the
// renderer, and checks every cycle against a word-level burst model.
module tb_vram_burst_fetch;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] fifo_m [$];
    logic        pend_strobe;
    logic [14:0] pend_addr;

    vram_burst_fetch_if #(.CNT_W(CNT_W)) bif ();

    vram_burst_fetch #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Content of VRAM word a, distinct for every address.
    function automatic logic [31:0] vram_word(input logic [14:0] a);
        return {~a, 2'b10, a};
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_busy"},   32'(bif.busy),       32'd0);
        check_eq({pfx, "_done"},   32'(bif.done),       32'd0);
        check_eq({pfx, "_strobe"}, 32'(bif.bus_strobe), 32'd0);
        check_eq({pfx, "_addr"},   32'(bif.bus_addr),   32'd0);
        check_eq({pfx, "_valid"},  32'(bif.out_valid),  32'd0);
        check_eq({pfx, "_data"},   bif.out_data,        32'd0);
    endtask

    // One burst: accepted start, then a cycle-by-cycle comparison against the model.
    task automatic run_burst(input logic [14:0] sa, input int cnt, input int ack_pct,
                             input int rdy_pct, input int deny_at, input int deny_len,
                             input int rdy_hold, input int inj_at, input int abort_acks,
                             output int cycles);
        int          acks;
        int          pops;
        int          cyc;
        int          occ;
        bit          done_due;
        bit          finished;
        bit          aborted;
        logic        ack_now;
        logic        exp_strobe;
        logic [14:0] exp_addr;
        fifo_m.delete();
        pend_strobe = 1'b0;
        acks = 0; pops = 0; cyc = 0;
        done_due = 1'b0; finished = 1'b0; aborted = 1'b0;

        @(negedge clk);
        bif.start      = 1'b1;
        bif.start_addr = sa;
        bif.word_count = cnt[CNT_W-1:0];
        bif.bus_ack    = 1'b0;
        bif.out_ready  = 1'b0;
        #1;
        check_eq("idle_busy",   32'(bif.busy),       32'd0);
        check_eq("idle_strobe", 32'(bif.bus_strobe), 32'd0);
        if (cnt == 0) done_due = 1'b1;
        @(posedge clk);

        while (!finished && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bif.start      = (cyc == inj_at);
            bif.start_addr = sa ^ 15'h2AAA;
            bif.word_count = CNT_W'($urandom());
            ack_now = pend_strobe && ($urandom_range(99) < ack_pct) &&
                      !(cyc >= deny_at && cyc < deny_at + deny_len);
            bif.bus_ack    = ack_now;
            bif.bus_rddata = ack_now ? vram_word(pend_addr) : $urandom();
            bif.out_ready  = (cyc > rdy_hold) && ($urandom_range(99) < rdy_pct);
            #1;
            occ = fifo_m.size();
            check_eq("done", 32'(bif.done), 32'(done_due));
            check_eq("busy", 32'(bif.busy), 32'((cnt != 0) && !done_due));
            if (done_due) finished = 1'b1;
            exp_strobe = (cnt != 0) && !done_due && (cnt - acks - int'(ack_now) != 0) &&
                         (occ + int'(ack_now) < DEPTH);
            check_eq("strobe", 32'(bif.bus_strobe), 32'(exp_strobe));
            if (bif.bus_strobe) begin
                exp_addr = sa + 15'(acks + int'(ack_now));
                check_eq("addr", 32'(bif.bus_addr), 32'(exp_addr));
            end
            check_eq("valid", 32'(bif.out_valid), 32'(occ != 0));
            if (bif.out_valid && bif.out_ready && occ != 0) begin
                check_eq("data", bif.out_data, fifo_m.pop_front());
                pops++;
                if (pops == cnt) done_due = 1'b1;
            end
            if (ack_now) begin
                exp_addr = sa + 15'(acks);
                fifo_m.push_back(vram_word(exp_addr));
                acks++;
            end
            pend_strobe = bif.bus_strobe;
            pend_addr   = bif.bus_addr;
            if (abort_acks >= 0 && acks >= abort_acks) begin
                aborted  = 1'b1;
                finished = 1'b1;
            end
        end
        bif.start = 1'b0;
        if (!aborted) begin
            check_eq("burst_end", 32'(finished), 32'd1);
            check_eq("words_out", 32'(pops), 32'(cnt));
            check_eq("fifo_left", 32'(fifo_m.size()), 32'd0);
        end
        cycles = cyc;
    endtask

    initial begin
        int cyc;
        int rc;
        int inj;
        bif.start      = 1'b0;
        bif.start_addr = 15'd0;
        bif.word_count = '0;
        bif.bus_ack    = 1'b0;
        bif.bus_rddata = 32'd0;
        bif.out_ready  = 1'b0;
        pend_strobe    = 1'b0;
        pend_addr      = 15'd0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle port, consumer always ready: one word per cycle.
        run_burst(15'h0100, 4, 100, 100, -1, 0, 0, -1, -1, cyc);
        check_eq("latency", 32'(cyc), 32'd7);
        // Port pre-empted for 3 cycles after the second strobe.
        run_burst(15'h0100, 6, 100, 100, 3, 3, 0, -1, -1, cyc);
        // Consumer stalled: strobe must stop at a full FIFO, then resume.
        run_burst(15'h0300, 10, 100, 100, -1, 0, 12, -1, -1, cyc);
        // Address wrap at the top of VRAM.
        run_burst(15'h7FFE, 3, 100, 100, -1, 0, 0, -1, -1, cyc);
        // Empty burst.
        run_burst(15'h1234, 0, 100, 100, -1, 0, 0, -1, -1, cyc);
        check_eq("empty_latency", 32'(cyc), 32'd1);
        // Start while busy must not disturb the running burst.
        run_burst(15'h0040, 5, 100, 50, -1, 0, 0, 3, -1, cyc);

        // Reset after two acks mid-burst.
        run_burst(15'h0200, 8, 100, 0, -1, 0, 1000, -1, 2, cyc);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n          = 1'b1;
        bif.bus_ack    = 1'b1;
        bif.bus_rddata = 32'hDEADBEEF;
        bif.out_ready  = 1'b0;
        #1;
        check_eq("stray_strobe", 32'(bif.bus_strobe), 32'd0);
        @(negedge clk);
        bif.bus_ack = 1'b0;
        #1;
        check_reset_outputs("stray");

        // Randomized bursts with random grant and consumer behaviour.
        for (int k = 0; k < 25; k++) begin
            rc  = int'($urandom_range(20));
            inj = ($urandom_range(3) == 0) ? 2 : -1;
            run_burst(15'($urandom()), rc, int'($urandom_range(100, 30)),
                      int'($urandom_range(100, 20)), -1, 0, int'($urandom_range(6)),
                      inj, -1, cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
